ponylink_stream_arbiter: RTL and testbench

- Shares the single in_t* stream input of a ponylink_master or ponylink_slave core between NUM_PORTS local AXI-stream requesters.
- Arbitration is round-robin at burst granularity.
- Each burst is optionally prefixed by a header beat carrying the requester index, so the far end can demultiplex.
- Bursts are bounded by tlast or by MAX_BEATS, so free-running sources with tlast tied low cannot starve other requesters.

---
 rtl/ponylink_stream_arbiter_if.sv | 25 ++
 rtl/ponylink_stream_arbiter.sv | 125 ++++++++++++
 tb/tb_ponylink_stream_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ponylink_stream_arbiter_if.sv
// Stream bundle between NUM_PORTS local AXI-stream requesters, the arbiter and the PonyLink core
// input. The master modport is the arbiter's view of the bundle.
interface ponylink_stream_arbiter_if #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned TDATA_WIDTH = 16
);
  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_tdata;
  logic [NUM_PORTS-1:0]             in_tvalid;
  logic [NUM_PORTS-1:0]             in_tlast;
  logic [NUM_PORTS-1:0]             in_tready;
  logic [TDATA_WIDTH-1:0]           out_tdata;
  logic                             out_tvalid;
  logic                             out_tlast;
  logic                             out_tready;

  modport master (
    input  in_tdata, in_tvalid, in_tlast, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    output in_tdata, in_tvalid, in_tlast, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/ponylink_stream_arbiter.sv
// Burst-granular round-robin arbiter that merges NUM_PORTS AXI streams into one PonyLink input,
// optionally prefixing each burst with a header beat carrying the requester index.
module ponylink_stream_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned TDATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned HEADER_EN   = 1,
  parameter int unsigned MAX_BEATS   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      linkready,
  ponylink_stream_arbiter_if.master bus,
  output logic [ID_WIDTH-1:0]       grant_id,
  output logic                      busy
);

  localparam int unsigned CntW = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CntW-1:0] LastBeat = (MAX_BEATS == 0) ? '0 : CntW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  state_e                 state_q;
  logic [ID_WIDTH-1:0]    grant_q;
  logic [CntW-1:0]        cnt_q;

  logic [ID_WIDTH-1:0]    pick_id;
  logic                   sel_valid;
  logic                   sel_last;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   cap_hit;
  logic                   handshake;

  // Lowest rotated distance from the previous owner wins; the owner itself sits at the far end.
  always_comb begin
    int unsigned off;
    int unsigned best_off;
    pick_id  = grant_q;
    best_off = NUM_PORTS;
    off      = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      off = (i + NUM_PORTS - 1 - 32'(grant_q)) % NUM_PORTS;
      if (bus.in_tvalid[i] && (off < best_off)) begin
        best_off = off;
        pick_id  = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = bus.in_tvalid[i];
        sel_last  = bus.in_tlast[i];
        sel_data  = bus.in_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  assign cap_hit = (MAX_BEATS != 0) && (cnt_q == LastBeat);

  always_comb begin
    bus.out_tvalid = 1'b0;
    bus.out_tlast  = 1'b0;
    bus.out_tdata  = '0;
    bus.in_tready  = '0;
    case (state_q)
      StHeader: begin
        bus.out_tvalid                = 1'b1;
        bus.out_tdata[ID_WIDTH-1:0]   = grant_q;
      end
      StData: begin
        bus.out_tvalid = sel_valid;
        bus.out_tdata  = sel_data;
        bus.out_tlast  = sel_last | cap_hit;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          bus.in_tready[i] = (grant_q == ID_WIDTH'(i)) & bus.out_tready;
        end
      end
      default: ;
    endcase
  end

  assign handshake = bus.out_tvalid & bus.out_tready;

  // linkready only gates new grants; a burst in flight always runs to its last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= ID_WIDTH'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (linkready && (|bus.in_tvalid)) begin
            grant_q <= pick_id;
            cnt_q   <= '0;
            state_q <= (HEADER_EN != 0) ? StHeader : StData;
          end
        end
        StHeader: begin
          if (bus.out_tready) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (handshake) begin
            cnt_q <= cnt_q + CntW'(1);
            if (bus.out_tlast) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ponylink_stream_arbiter.sv
// Bench for ponylink_stream_arbiter: cycle vectors, stream scoreboards against a queue-based
// burst model, and a reset-mid-burst sequence.
module tb_ponylink_stream_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;
  localparam int Budget = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic linkready = 1'b0;
  logic out_tready = 1'b0;
  logic sel = 1'b0;
  logic [NP*DW-1:0] in_tdata = '0;
  logic [NP-1:0] in_tvalid = '0;
  logic [NP-1:0] in_tlast = '0;

  always #5 clk = ~clk;

  ponylink_stream_arbiter_if #(.NUM_PORTS(NP), .TDATA_WIDTH(DW)) bus_a ();
  ponylink_stream_arbiter_if #(.NUM_PORTS(NP), .TDATA_WIDTH(DW)) bus_b ();

  assign bus_a.in_tdata   = in_tdata;
  assign bus_a.in_tvalid  = in_tvalid;
  assign bus_a.in_tlast   = in_tlast;
  assign bus_a.out_tready = out_tready;
  assign bus_b.in_tdata   = in_tdata;
  assign bus_b.in_tvalid  = in_tvalid;
  assign bus_b.in_tlast   = in_tlast;
  assign bus_b.out_tready = out_tready;

  logic [IW-1:0] grant_a, grant_b;
  logic busy_a, busy_b;

  ponylink_stream_arbiter #(
    .NUM_PORTS(NP), .TDATA_WIDTH(DW), .ID_WIDTH(IW), .HEADER_EN(1), .MAX_BEATS(16)
  ) dut (
    .clk(clk), .reset(rst), .linkready(linkready), .bus(bus_a), .grant_id(grant_a),
    .busy(busy_a)
  );

  ponylink_stream_arbiter #(
    .NUM_PORTS(NP), .TDATA_WIDTH(DW), .ID_WIDTH(IW), .HEADER_EN(0), .MAX_BEATS(0)
  ) dut_nh (
    .clk(clk), .reset(rst), .linkready(linkready), .bus(bus_b), .grant_id(grant_b),
    .busy(busy_b)
  );

  logic [DW-1:0] s_tdata;
  logic s_tvalid, s_tlast, s_busy;
  logic [NP-1:0] s_rdy;
  always_comb begin
    if (sel) begin
      s_tdata = bus_b.out_tdata; s_tvalid = bus_b.out_tvalid; s_tlast = bus_b.out_tlast;
      s_rdy = bus_b.in_tready; s_busy = busy_b;
    end else begin
      s_tdata = bus_a.out_tdata; s_tvalid = bus_a.out_tvalid; s_tlast = bus_a.out_tlast;
      s_rdy = bus_a.in_tready; s_busy = busy_a;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, lr, otr;
    logic [NP-1:0] v, l;
    logic [DW-1:0] d;
    logic e_v, e_l;
    logic [NP-1:0] e_rdy;
    logic [DW-1:0] e_d;
    logic e_busy;
    logic [IW-1:0] e_g;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic lr, input logic otr, input logic [3:0] v,
                              input logic [3:0] l, input logic [15:0] d, input logic e_v,
                              input logic e_l, input logic [3:0] e_rdy, input logic [15:0] e_d,
                              input logic e_busy, input logic [1:0] e_g);
    vec_t t;
    t.rst = r; t.lr = lr; t.otr = otr; t.v = v; t.l = l; t.d = d;
    t.e_v = e_v; t.e_l = e_l; t.e_rdy = e_rdy; t.e_d = e_d; t.e_busy = e_busy; t.e_g = e_g;
    return t;
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic l;
  } beat_t;

  beat_t src_q[NP][$];
  beat_t exp_q[$];
  beat_t got_q[$];

  // Reference: walk per-port queues burst by burst, starting after the reset owner NP-1.
  task automatic build_model(input int hen, input int mb);
    beat_t m[NP][$];
    beat_t b;
    int g, p, n;
    bit last;
    for (int i = 0; i < NP; i++) m[i] = src_q[i];
    exp_q.delete();
    g = NP - 1;
    forever begin
      p = -1;
      for (int k = 1; k <= NP; k++) begin
        if (p < 0 && m[(g + k) % NP].size() > 0) p = (g + k) % NP;
      end
      if (p < 0) break;
      g = p;
      if (hen != 0) exp_q.push_back('{d: DW'(g), l: 1'b0});
      n = 0;
      last = 1'b0;
      while (!last && m[p].size() > 0) begin
        b = m[p].pop_front();
        last = b.l || (mb != 0 && n == mb - 1);
        exp_q.push_back('{d: b.d, l: last});
        n++;
      end
    end
  endtask

  task automatic run_sb(input string name, input bit s, input int hen, input int mb,
                        input int rdy_pct);
    int cyc, errs, bad;
    bit pstall, pend;
    logic [DW-1:0] pd;
    logic pl;
    sel = s;
    build_model(hen, mb);
    got_q.delete();
    @(negedge clk);
    rst = 1'b1; in_tvalid = '0; in_tlast = '0; out_tready = 1'b0; linkready = 1'b0;
    @(negedge clk);
    rst = 1'b0; linkready = 1'b1;
    cyc = 0; errs = 0; pstall = 1'b0; pd = '0; pl = 1'b0; pend = 1'b1;
    while (pend && cyc < Budget) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (src_q[i].size() > 0) begin
          in_tvalid[i] = 1'b1;
          in_tdata[i*DW +: DW] = src_q[i][0].d;
          in_tlast[i] = src_q[i][0].l;
        end else begin
          in_tvalid[i] = 1'b0;
          in_tlast[i] = 1'b0;
        end
      end
      out_tready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (pstall && (!s_tvalid || s_tdata !== pd || s_tlast !== pl)) errs++;
      if ($countones(s_rdy) > 1) errs++;
      if (s_tvalid && out_tready) got_q.push_back('{d: s_tdata, l: s_tlast});
      for (int i = 0; i < NP; i++) begin
        if (s_rdy[i] && in_tvalid[i]) begin
          if (!(s_tvalid && out_tready && s_tdata === src_q[i][0].d)) errs++;
          void'(src_q[i].pop_front());
        end
      end
      pstall = s_tvalid && !out_tready;
      pd = s_tdata;
      pl = s_tlast;
      pend = s_busy;
      for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) pend = 1'b1;
      cyc++;
    end
    in_tvalid = '0;
    in_tlast = '0;
    chk({name, " finished"}, 64'(cyc < Budget), 64'd1);
    chk({name, " beat count"}, 64'(got_q.size()), 64'(exp_q.size()));
    bad = 0;
    for (int j = 0; j < exp_q.size() && j < got_q.size() && bad < 8; j++) begin
      if (got_q[j] !== exp_q[j]) bad++;
      chk($sformatf("%s beat%0d {data,last}", name, j), 64'(got_q[j]), 64'(exp_q[j]));
    end
    chk({name, " protocol errors"}, 64'(errs), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int seq;

    // Single requester burst, then linkready gating, header and data stalls.
    vt.push_back(mk(1, 0, 1, 4'b0000, 4'b0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 0, 2'd3));
    vt.push_back(mk(0, 1, 1, 4'b0100, 4'b0000, 16'hA001, 0, 0, 4'b0000, 16'h0000, 0, 2'd3));
    vt.push_back(mk(0, 1, 1, 4'b0100, 4'b0000, 16'hA001, 1, 0, 4'b0000, 16'h0002, 1, 2'd2));
    vt.push_back(mk(0, 1, 1, 4'b0100, 4'b0000, 16'hA001, 1, 0, 4'b0100, 16'hA001, 1, 2'd2));
    vt.push_back(mk(0, 1, 1, 4'b0100, 4'b0000, 16'hA002, 1, 0, 4'b0100, 16'hA002, 1, 2'd2));
    vt.push_back(mk(0, 1, 1, 4'b0100, 4'b0100, 16'hA003, 1, 1, 4'b0100, 16'hA003, 1, 2'd2));
    vt.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 0, 2'd2));
    vt.push_back(mk(0, 0, 1, 4'b0010, 4'b0010, 16'hB001, 0, 0, 4'b0000, 16'h0000, 0, 2'd2));
    vt.push_back(mk(0, 0, 1, 4'b0010, 4'b0010, 16'hB001, 0, 0, 4'b0000, 16'h0000, 0, 2'd2));
    vt.push_back(mk(0, 1, 0, 4'b0010, 4'b0010, 16'hB001, 0, 0, 4'b0000, 16'h0000, 0, 2'd2));
    vt.push_back(mk(0, 1, 0, 4'b0010, 4'b0010, 16'hB001, 1, 0, 4'b0000, 16'h0001, 1, 2'd1));
    vt.push_back(mk(0, 0, 0, 4'b0010, 4'b0010, 16'hB001, 1, 0, 4'b0000, 16'h0001, 1, 2'd1));
    vt.push_back(mk(0, 0, 1, 4'b0010, 4'b0010, 16'hB001, 1, 0, 4'b0000, 16'h0001, 1, 2'd1));
    vt.push_back(mk(0, 0, 0, 4'b0010, 4'b0010, 16'hB001, 1, 1, 4'b0000, 16'hB001, 1, 2'd1));
    vt.push_back(mk(0, 0, 1, 4'b0010, 4'b0010, 16'hB001, 1, 1, 4'b0010, 16'hB001, 1, 2'd1));
    vt.push_back(mk(0, 1, 1, 4'b0000, 4'b0000, 16'h0000, 0, 0, 4'b0000, 16'h0000, 0, 2'd1));

    sel = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst = vt[i].rst; linkready = vt[i].lr; out_tready = vt[i].otr;
      in_tvalid = vt[i].v; in_tlast = vt[i].l; in_tdata = {NP{vt[i].d}};
      #1;
      chk($sformatf("vec%0d {v,l,rdy,d,busy,g}", i),
          {s_tvalid, s_tlast, s_rdy, (vt[i].e_v ? s_tdata : 16'h0), s_busy, grant_a},
          {vt[i].e_v, vt[i].e_l, vt[i].e_rdy, vt[i].e_d, vt[i].e_busy, vt[i].e_g});
    end

    // All ports continuously valid, no tlast: forced bursts of 16 in order 0,1,2,3,0,...
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      for (int s = 0; s < 32; s++) src_q[i].push_back('{d: {4'(i), 12'(s)}, l: 1'b0});
    end
    run_sb("round_robin", 1'b0, 1, 16, 100);

    // Random packets with random core backpressure.
    for (int i = 0; i < NP; i++) begin
      int npk, len;
      src_q[i].delete();
      seq = 0;
      npk = $urandom_range(1, 3);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 40);
        for (int b = 0; b < len; b++) begin
          src_q[i].push_back('{d: {4'(i), 12'(seq)}, l: (b == len - 1)});
          seq++;
        end
      end
    end
    run_sb("random_stall", 1'b0, 1, 16, 60);

    // No header, unlimited bursts: 100 beats from port 3 with tlast only on the last.
    for (int i = 0; i < NP; i++) src_q[i].delete();
    for (int s = 0; s < 100; s++) src_q[3].push_back('{d: {4'h3, 12'(s)}, l: (s == 99)});
    run_sb("no_header_100", 1'b1, 0, 0, 70);

    // Reset in DATA after 5 beats, then ports 0 and 3 compete.
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b1; linkready = 1'b0; in_tvalid = '0; in_tlast = '0; out_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0; linkready = 1'b1; in_tvalid = 4'b0100; in_tdata = {NP{16'hC005}};
    repeat (7) @(negedge clk);
    #1;
    chk("pre-reset in data {busy,v}", {busy_a, bus_a.out_tvalid}, 2'b11);
    rst = 1'b1;
    #1;
    chk("reset outputs {v,l,rdy,busy}",
        {bus_a.out_tvalid, bus_a.out_tlast, bus_a.in_tready, busy_a}, 7'd0);
    chk("reset grant", grant_a, 2'd3);
    @(negedge clk);
    rst = 1'b0; in_tvalid = 4'b1001; in_tdata = {16'hD003, 16'h0000, 16'h0000, 16'hD000};
    #1;
    chk("post-reset idle busy", busy_a, 1'b0);
    @(negedge clk);
    #1;
    chk("post-reset header {v,d,g}", {bus_a.out_tvalid, bus_a.out_tdata, grant_a},
        {1'b1, 16'h0000, 2'd0});
    in_tvalid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
